// File: rtl/waveform_frame_streamer_if.sv
// rtl/waveform_frame_streamer_if.sv - sample stream handshake between streamer and consumer
interface waveform_frame_streamer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] sample_out;
    logic              sample_valid;
    logic              sample_ready;

    modport master (output sample_out, output sample_valid, input sample_ready);
    modport slave  (input sample_out, input sample_valid, output sample_ready);
endinterface

// File: rtl/waveform_frame_streamer.sv
// rtl/waveform_frame_streamer.sv - double-buffered frame capture with paced sample playout
// A new frame lands in the idle buffer and is swapped in only at a frame boundary.
module waveform_frame_streamer #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_rdy,
    input  logic [DATA_W-1:0]      frame_in [0:DEPTH-1],
    input  logic [DIV_W-1:0]       rate_div,
    input  logic                   loop_en,
    input  logic                   stop,
    waveform_frame_streamer_if.master stream,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, PACE, SEND} state_t;

    state_t              state, next_state;
    logic [DATA_W-1:0]   bufs [0:1][0:DEPTH-1];
    logic                act, pend, rdy_q;
    logic [IDX_W-1:0]    idx;
    logic [DIV_W-1:0]    cnt, rate_q;
    logic [DATA_W-1:0]   sample_q;
    logic                rise, hs, last, cap_act, cap_alt, swap, wr_sel;

    assign rise   = frame_rdy & ~rdy_q;
    assign hs     = (state == SEND) & stream.sample_ready;
    assign last   = (idx == IDX_W'(DEPTH - 1));
    assign wr_sel = cap_act ? act : ~act;

    assign stream.sample_out   = sample_q;
    assign stream.sample_valid = (state == SEND);
    assign busy                = (state != IDLE);

    always_comb begin
        next_state = state;
        cap_act    = 1'b0;
        cap_alt    = 1'b0;
        swap       = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    next_state = PACE;
                    cap_act    = 1'b1;
                end
            end
            PACE: begin
                cap_alt = rise;
                if (cnt == rate_q)
                    next_state = SEND;
            end
            SEND: begin
                cap_alt = rise;
                if (hs) begin
                    // A frame arriving on the final handshake counts as pending.
                    swap = last & (pend | rise);
                    if (!last || pend || rise || loop_en)
                        next_state = PACE;
                    else
                        next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (stop) begin
            next_state = IDLE;
            cap_act    = 1'b0;
            cap_alt    = 1'b0;
            swap       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_act | cap_alt) begin
            for (int i = 0; i < DEPTH; i++)
                bufs[wr_sel][i] <= frame_in[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            act        <= 1'b0;
            pend       <= 1'b0;
            rdy_q      <= 1'b0;
            idx        <= '0;
            cnt        <= '0;
            rate_q     <= '0;
            sample_q   <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rdy_q <= frame_rdy;
            state <= next_state;
            if (stop) begin
                pend       <= 1'b0;
                overrun    <= 1'b0;
                idx        <= '0;
                cnt        <= '0;
                frame_done <= 1'b0;
            end else begin
                frame_done <= hs & last;
                if (cap_alt) begin
                    pend <= 1'b1;
                    if (pend)
                        overrun <= 1'b1;
                end
                if (cap_act) begin
                    idx    <= '0;
                    cnt    <= '0;
                    rate_q <= rate_div;
                end
                if (state == PACE) begin
                    if (cnt == rate_q) begin
                        sample_q <= bufs[act][idx];
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                if (hs) begin
                    // idx is exactly log2(DEPTH) wide, so the last sample wraps it to 0.
                    idx    <= idx + 1'b1;
                    cnt    <= '0;
                    rate_q <= rate_div;
                    if (swap) begin
                        act  <= ~act;
                        pend <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_waveform_frame_streamer.sv
// tb/tb_waveform_frame_streamer.sv - scoreboard bench for waveform_frame_streamer
module tb_waveform_frame_streamer;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_rdy = 1'b0;
    logic [7:0]  frame [0:DEPTH-1];
    logic [15:0] rate_div = '0;
    logic        loop_en = 1'b0;
    logic        stop = 1'b0;
    logic        busy, frame_done, overrun;

    waveform_frame_streamer_if #(.DATA_W(8)) stream ();

    waveform_frame_streamer #(.DEPTH(DEPTH), .DATA_W(8), .DIV_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_rdy  (frame_rdy),
        .frame_in   (frame),
        .rate_div   (rate_div),
        .loop_en    (loop_en),
        .stop       (stop),
        .stream     (stream),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        bit         last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, fails = 0, cyc = 0;
    int   n_hs = 0, done_cnt = 0, last_hs_cyc = 0, gap_min = 0, gap_max = 0;
    bit   have_last = 0, done_due = 0, prev_vld = 0, prev_rdy = 0, prev_stop = 0;
    logic [7:0] prev_out = '0;
    exp_t e;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are judged at the falling edge, i.e. what the next rising edge will see.
    always @(negedge clk) begin
        if (rst) begin
            done_due = 0;
            prev_vld = 0;
        end else begin
            checks++;
            if (frame_done !== done_due) begin
                fails++;
                $display("FAIL frame_done_timing: got %b required %b at cycle %0d", frame_done, done_due, cyc);
            end
            if (frame_done === 1'b1) done_cnt++;
            done_due = 0;
            if (prev_vld && !prev_rdy && !prev_stop) begin
                checks++;
                if (stream.sample_valid !== 1'b1 || stream.sample_out !== prev_out) begin
                    fails++;
                    $display("FAIL hold_stable: valid %b data %h required valid 1 data %h", stream.sample_valid, stream.sample_out, prev_out);
                end
            end
            if (stream.sample_valid === 1'b1 && stream.sample_ready === 1'b1 && !stop) begin
                n_hs++;
                if (have_last) begin
                    if (cyc - last_hs_cyc < gap_min) gap_min = cyc - last_hs_cyc;
                    if (cyc - last_hs_cyc > gap_max) gap_max = cyc - last_hs_cyc;
                end
                have_last   = 1;
                last_hs_cyc = cyc;
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_sample: got %h with nothing required", stream.sample_out);
                end else begin
                    e = sb.pop_front();
                    if (stream.sample_out !== e.d) begin
                        fails++;
                        $display("FAIL sample_data: got %h required %h at handshake %0d", stream.sample_out, e.d, n_hs);
                    end
                    done_due = e.last;
                end
            end
            prev_vld  = stream.sample_valid;
            prev_rdy  = stream.sample_ready;
            prev_stop = stop;
            prev_out  = stream.sample_out;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_gaps();
        have_last = 0;
        gap_min   = 1000000;
        gap_max   = 0;
    endtask

    task automatic push_frame();
        for (int i = 0; i < DEPTH; i++) sb.push_back('{frame[i], i == DEPTH - 1});
    endtask

    task automatic pulse_rdy();
        frame_rdy = 1'b1;
        tick(1);
        frame_rdy = 1'b0;
    endtask

    task automatic wait_hs(input int target, input int limit);
        int g = 0;
        while (n_hs < target && g < limit) begin
            tick(1);
            g++;
        end
        checks++;
        if (n_hs < target) begin
            fails++;
            $display("FAIL wait_hs_timeout: handshakes %0d required %0d", n_hs, target);
        end
    endtask

    task automatic wait_empty(input int limit);
        int g = 0;
        while (sb.size() != 0 && g < limit) begin
            tick(1);
            g++;
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d samples left required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        stream.sample_ready = 1'b0;
        tick(3);
        checks += 5;
        if (stream.sample_out !== 8'h00) begin fails++; $display("FAIL reset_sample_out: got %h required 00", stream.sample_out); end
        if (stream.sample_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b required 0", stream.sample_valid); end
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
        if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b required 0", overrun); end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_single_frame();
        int t0, d0, g;
        rate_div = 0; loop_en = 0; stream.sample_ready = 1'b1;
        reset_gaps();
        d0 = done_cnt;
        for (int i = 0; i < DEPTH; i++) frame[i] = 8'(i);
        push_frame();
        frame_rdy = 1'b1;
        t0 = cyc;
        g = 0;
        do begin
            tick(1);
            g++;
        end while (stream.sample_valid !== 1'b1 && g < 20);
        checks++;
        if (cyc - t0 != 2) begin fails++; $display("FAIL first_latency: got %0d cycles required 2", cyc - t0); end
        frame_rdy = 1'b0;
        wait_empty(2000);
        tick(3);
        checks += 5;
        if (done_cnt - d0 != 1) begin fails++; $display("FAIL single_done_count: got %0d required 1", done_cnt - d0); end
        if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_end: got %b required 0", busy); end
        if (stream.sample_valid !== 1'b0) begin fails++; $display("FAIL single_valid_end: got %b required 0", stream.sample_valid); end
        if (gap_min != 2) begin fails++; $display("FAIL single_period_min: got %0d required 2", gap_min); end
        if (gap_max != 2) begin fails++; $display("FAIL single_period_max: got %0d required 2", gap_max); end
    endtask

    task automatic test_backpressure();
        int d0, g;
        rate_div = 3;
        reset_gaps();
        d0 = done_cnt;
        for (int i = 0; i < DEPTH; i++) frame[i] = 8'(i * 37 + 5);
        push_frame();
        frame_rdy = 1'b1;
        g = 0;
        while (sb.size() != 0 && g < 6000) begin
            tick(1);
            frame_rdy = 1'b0;
            stream.sample_ready = 1'($urandom_range(0, 1));
            g++;
        end
        stream.sample_ready = 1'b1;
        wait_empty(100);
        tick(3);
        checks += 3;
        if (gap_min < 5) begin fails++; $display("FAIL bp_min_gap: got %0d required >= 5", gap_min); end
        if (done_cnt - d0 != 1) begin fails++; $display("FAIL bp_done_count: got %0d required 1", done_cnt - d0); end
        if (busy !== 1'b0) begin fails++; $display("FAIL bp_busy_end: got %b required 0", busy); end
        rate_div = 0;
    endtask

    task automatic test_loop();
        int d0;
        loop_en = 1'b1;
        reset_gaps();
        d0 = done_cnt;
        for (int i = 0; i < DEPTH; i++) frame[i] = 8'(i);
        repeat (3) push_frame();
        frame_rdy = 1'b1;
        tick(1);
        for (int i = 0; i < DEPTH; i++) frame[i] = 8'hAA;
        wait_empty(3000);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        loop_en = 1'b0;
        frame_rdy = 1'b0;
        tick(2);
        checks += 3;
        if (done_cnt - d0 != 3) begin fails++; $display("FAIL loop_done_count: got %0d required 3", done_cnt - d0); end
        if (gap_max != 2) begin fails++; $display("FAIL loop_wrap_gap: got %0d required 2", gap_max); end
        if (busy !== 1'b0) begin fails++; $display("FAIL loop_stop_busy: got %b required 0", busy); end
    endtask

    task automatic test_mid_frame();
        int base;
        for (int i = 0; i < DEPTH; i++) frame[i] = 8'h11;
        push_frame();
        base = n_hs;
        pulse_rdy();
        wait_hs(base + 100, 1000);
        for (int i = 0; i < DEPTH; i++) frame[i] = 8'hEE;
        push_frame();
        pulse_rdy();
        wait_empty(2000);
        tick(3);
        checks++;
        if (overrun !== 1'b0) begin fails++; $display("FAIL mid_no_overrun: got %b required 0", overrun); end

        for (int i = 0; i < DEPTH; i++) frame[i] = 8'h11;
        push_frame();
        base = n_hs;
        pulse_rdy();
        wait_hs(base + 100, 1000);
        for (int i = 0; i < DEPTH; i++) frame[i] = 8'hEE;
        pulse_rdy();
        wait_hs(base + 150, 1000);
        for (int i = 0; i < DEPTH; i++) frame[i] = 8'h5A;
        push_frame();
        pulse_rdy();
        wait_empty(2000);
        tick(3);
        checks++;
        if (overrun !== 1'b1) begin fails++; $display("FAIL mid_overrun_set: got %b required 1", overrun); end
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin fails++; $display("FAIL mid_overrun_clear: got %b required 0", overrun); end
    endtask

    task automatic test_back_to_back();
        int d0, g;
        reset_gaps();
        d0 = done_cnt;
        for (int i = 0; i < DEPTH; i++) frame[i] = 8'(i);
        push_frame();
        pulse_rdy();
        for (int i = 0; i < DEPTH; i++) frame[i] = 8'(255 - i);
        push_frame();
        g = 0;
        while (!(stream.sample_valid === 1'b1 && stream.sample_out === 8'hFF) && g < 2000) begin
            tick(1);
            g++;
        end
        frame_rdy = 1'b1;
        tick(1);
        frame_rdy = 1'b0;
        wait_empty(2000);
        tick(3);
        checks += 4;
        if (gap_max != 2) begin fails++; $display("FAIL b2b_no_gap: got max gap %0d required 2", gap_max); end
        if (done_cnt - d0 != 2) begin fails++; $display("FAIL b2b_done_count: got %0d required 2", done_cnt - d0); end
        if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_overrun: got %b required 0", overrun); end
        if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_end: got %b required 0", busy); end
    endtask

    task automatic test_stop();
        int base;
        for (int i = 0; i < DEPTH; i++) frame[i] = 8'(i);
        push_frame();
        base = n_hs;
        pulse_rdy();
        wait_hs(base + 20, 1000);
        pulse_rdy();
        tick(2);
        pulse_rdy();
        tick(1);
        checks++;
        if (overrun !== 1'b1) begin fails++; $display("FAIL stop_overrun_pre: got %b required 1", overrun); end
        wait_hs(base + 50, 1000);
        stream.sample_ready = 1'b0;
        tick(1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        checks += 3;
        if (stream.sample_valid !== 1'b0) begin fails++; $display("FAIL stop_valid: got %b required 0", stream.sample_valid); end
        if (busy !== 1'b0) begin fails++; $display("FAIL stop_busy: got %b required 0", busy); end
        if (overrun !== 1'b0) begin fails++; $display("FAIL stop_overrun_clear: got %b required 0", overrun); end
        sb.delete();
        stream.sample_ready = 1'b1;
        tick(3);
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL stop_stays_idle: got %b required 0", busy); end
    endtask

    task automatic test_async_rst();
        int g;
        stream.sample_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) frame[i] = 8'(i + 1);
        push_frame();
        pulse_rdy();
        tick(1);
        pulse_rdy();
        tick(1);
        pulse_rdy();
        g = 0;
        while (stream.sample_valid !== 1'b1 && g < 50) begin
            tick(1);
            g++;
        end
        checks += 2;
        if (stream.sample_out !== 8'h01) begin fails++; $display("FAIL rst_pre_sample: got %h required 01", stream.sample_out); end
        if (overrun !== 1'b1) begin fails++; $display("FAIL rst_pre_overrun: got %b required 1", overrun); end
        #2 rst = 1'b1;
        #1;
        checks += 5;
        if (stream.sample_out !== 8'h00) begin fails++; $display("FAIL rst_async_sample_out: got %h required 00", stream.sample_out); end
        if (stream.sample_valid !== 1'b0) begin fails++; $display("FAIL rst_async_valid: got %b required 0", stream.sample_valid); end
        if (busy !== 1'b0) begin fails++; $display("FAIL rst_async_busy: got %b required 0", busy); end
        if (overrun !== 1'b0) begin fails++; $display("FAIL rst_async_overrun: got %b required 0", overrun); end
        if (frame_done !== 1'b0) begin fails++; $display("FAIL rst_async_done: got %b required 0", frame_done); end
        tick(2);
        rst = 1'b0;
        sb.delete();
        stream.sample_ready = 1'b1;
        tick(3);
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL rst_needs_edge: got %b required 0", busy); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) frame[i] = 8'h00;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_loop();
        test_mid_frame();
        test_back_to_back();
        test_stop();
        test_async_rst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/waveform_frame_streamer.md
# waveform_frame_streamer

Downstream stage of the waveform converter. Captures each completed 256-sample, 8-bit frame when the converter raises its ready flag, then plays it out one sample at a time at a programmable rate over a valid/ready handshake toward the filter/DAC path. It double-buffers, so a new frame can arrive while the current one is playing without tearing. The new frame is swapped in only at a frame boundary.

## Interface
- DEPTH, 256: samples per frame; power of two.
- DATA_W, 8: sample width.
- DIV_W, 16: width of the rate divider.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- frame_rdy  in  1  converter ready flag (level); a 0→1 transition marks a new frame.
- frame_in  in  DATA_W×DEPTH  unpacked frame array [0:DEPTH-1], valid when frame_rdy rises.
- rate_div  in  DIV_W  extra idle cycles per sample; sampled at each PACE entry.
- loop_en  in  1  replay the current frame continuously when no new frame is pending.
- stop  in  1  synchronous abort and flag clear.
- sample_out  out  DATA_W  current sample.
- sample_valid  out  1  sample_out is valid.
- sample_ready  in  1  consumer accepts when high together with sample_valid.
- busy  out  1  state ≠ IDLE.
- frame_done  out  1  one-cycle pulse after the last sample of a frame is accepted.
- overrun  out  1  sticky; a pending frame was overwritten before it played.

## Operation
- Storage: two DEPTH×DATA_W buffers. `act` selects the playing buffer. `pend` flag. Index `idx` is log2(DEPTH) bits. Divider count `cnt` is DIV_W bits.
- Edge detect: `rdy_q` registers frame_rdy. `edge = frame_rdy & ~rdy_q`. `rdy_q` updates every cycle, including under stop.
- States: IDLE, PACE, SEND.
- IDLE + edge: copy frame_in into buffer `act`. Set idx=0, cnt=0. Go to PACE.
- PACE + edge, or SEND + edge: copy frame_in into buffer `~act`. If `pend` is already 1, set overrun=1. Set pend=1.
- PACE: cnt increments each cycle. When cnt == rate_div: load sample_out ← buf[act][idx], set cnt=0, go to SEND.
- SEND: sample_valid=1. sample_out is held stable until the handshake.
  - Handshake with idx < DEPTH-1: idx++, go to PACE.
  - Handshake with idx == DEPTH-1 (frame end): pulse frame_done next cycle.
    - Effective pending = pend | edge this cycle. If it is set: flip act, clear pend, idx=0, go to PACE.
    - Otherwise, if loop_en: idx=0, go to PACE.
    - Otherwise: go to IDLE.
- stop (highest priority): next cycle state=IDLE, sample_valid=0, pend=0, overrun=0, idx=0, cnt=0. A same-cycle edge is ignored. Buffer contents are don't-care.
- frame_rdy held high does not retrigger. A new frame requires a falling edge first.

## Timing
- Reset values:
  - sample_out=0, sample_valid=0, busy=0, frame_done=0, overrun=0.
  - state=IDLE, act=0, pend=0, idx=0, cnt=0, rdy_q=0.
  - Buffers need no reset.
- Edge sampled in IDLE at cycle T: PACE during T+1..T+1+rate_div. sample_valid=1 from T+2+rate_div.
- Handshake at cycle H: the next sample is valid at H+2+rate_div. With sample_ready held high, the sample period is rate_div+2 cycles. rate_div=0 gives 2 cycles per sample.
- frame_done is high exactly on the cycle after the final handshake.
- sample_valid never drops without a handshake, except on stop or rst.
- rst asserted mid-frame clears everything immediately (asynchronous). The first frame after reset needs a fresh frame_rdy edge. If frame_rdy is high when rst releases, rdy_q=0 makes it count as an edge on the first clock.

## Test plan
- Single frame, buffer = ramp i, rate_div=0, ready=1, loop_en=0:
  - sample_valid rises 2 cycles after the edge.
  - Samples are 0..255, one every 2 cycles.
  - frame_done pulses once; busy falls; state returns to IDLE.
- Backpressure, rate_div=3, ready toggled pseudo-randomly:
  - sample_out is held stable while valid & ~ready.
  - Consecutive handshakes are ≥5 cycles apart.
  - No sample is lost or duplicated.
- Loop, loop_en=1, no new frame:
  - The ramp repeats: 255 is followed by 0.
  - frame_done pulses every 256 samples.
  - A frame_rdy held high causes no recapture.
- Mid-frame update:
  - Frame A = all 0x11. Frame B = all 0xEE, edge at sample 100.
  - Samples 100..255 stay 0x11; sample 256 onward is 0xEE; overrun=0.
  - A third edge C before the boundary sets overrun=1 and C plays instead of B.
- Edge on the same cycle as the final handshake of A: B starts at idx 0 with no IDLE gap.
- stop at sample 50:
  - sample_valid=0 and busy=0 the next cycle; overrun is cleared.
  - Async rst mid-SEND zeroes all outputs without waiting for a clock edge.
